wb_trace_checker: RTL and testbench

- Parametrised, synthesisable self-checking monitor for the pipelined data_path.
- Sits beside data_path in the bench or on an FPGA top level.
- Holds a loadable table of expected write-back values and compares the live write-back stream against it in order.
- Reports pass, fail or timeout, and latches diagnostics on the first mismatch.

---
 rtl/wb_trace_checker_if.sv | 27 ++
 rtl/wb_trace_checker.sv | 171 +++++++++++++++++
 tb/tb_wb_trace_checker.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_trace_checker_if.sv
// rtl/wb_trace_checker_if.sv - write-back stream and expected-table load bus for wb_trace_checker
//
// Signals:
//   pc, wb_valid, wb_data    live write-back stream from data_path
//   exp_we, exp_addr, exp_data  expected-value table write port
// Modports:
//   master  drives the bus (data_path side / bench)
//   slave   observes the bus (the checker)
interface wb_trace_checker_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 4
);
    logic [DATA_W-1:0] pc;
    logic              wb_valid;
    logic [DATA_W-1:0] wb_data;
    logic              exp_we;
    logic [ADDR_W-1:0] exp_addr;
    logic [DATA_W-1:0] exp_data;

    modport master (
        output pc, wb_valid, wb_data, exp_we, exp_addr, exp_data
    );

    modport slave (
        input pc, wb_valid, wb_data, exp_we, exp_addr, exp_data
    );
endinterface

// File: rtl/wb_trace_checker.sv
// rtl/wb_trace_checker.sv - in-order write-back trace checker against a loadable expected table
//
// Compares the live write-back stream with a table of expected values and
// reports pass, fail or timeout, latching diagnostics on the first mismatch.
//
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   start         pulse: begin/restart a run (ignored while running)
//   num_exp       entries to check, sampled on start, clamped to DEPTH
//   bus           write-back stream and table write port (slave side)
//   done/pass/fail  run outcome flags
//   timeout       fail was caused by running out of cycles
//   err_*         index, observed data, expected data and pc of first mismatch
//   cycle_count   cycles spent in RUN
//   match_count   write-backs matched in the current run
module wb_trace_checker #(
    parameter int DATA_W  = 32,
    parameter int DEPTH   = 16,
    parameter int ADDR_W  = 4,
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 1000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [ADDR_W:0]     num_exp,
    wb_trace_checker_if.slave   bus,
    output logic                done,
    output logic                pass,
    output logic                fail,
    output logic                timeout,
    output logic [ADDR_W-1:0]   err_index,
    output logic [DATA_W-1:0]   err_got,
    output logic [DATA_W-1:0]   err_exp,
    output logic [DATA_W-1:0]   err_pc,
    output logic [CNT_W-1:0]    cycle_count,
    output logic [CNT_W-1:0]    match_count
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_PASS,
        S_FAIL
    } state_t;

    localparam logic [ADDR_W:0]  DEPTH_L  = (ADDR_W+1)'(DEPTH);
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);

    state_t state, state_next;

    logic [DATA_W-1:0] exp_mem [DEPTH];
    logic [ADDR_W-1:0] index;
    logic [ADDR_W:0]   num_lat;
    logic [ADDR_W:0]   num_clamped;
    logic [DATA_W-1:0] exp_cur;
    logic              is_last;

    // Control strobes from the next-state logic, consumed by the datapath.
    logic load;
    logic hit;
    logic miss;
    logic tmo;

    assign num_clamped = (num_exp > DEPTH_L) ? DEPTH_L : num_exp;

    // index never reaches num_lat, so it stays inside the table; the guard
    // only matters when DEPTH is not a power of two.
    assign exp_cur = ({1'b0, index} < DEPTH_L) ? exp_mem[index] : '0;
    assign is_last = ({1'b0, index} == (num_lat - 1'b1));

    assign done = (state == S_PASS) || (state == S_FAIL);
    assign pass = (state == S_PASS);
    assign fail = (state == S_FAIL);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        load       = 1'b0;
        hit        = 1'b0;
        miss       = 1'b0;
        tmo        = 1'b0;
        case (state)
            S_RUN: begin
                if (num_lat == '0) begin
                    state_next = S_PASS;
                end else if (bus.wb_valid && (bus.wb_data == exp_cur)) begin
                    hit = 1'b1;
                    if (is_last) begin
                        // A final match wins over a coincident timeout.
                        state_next = S_PASS;
                    end else if (cycle_count == TMO_LAST) begin
                        tmo        = 1'b1;
                        state_next = S_FAIL;
                    end
                end else if (bus.wb_valid) begin
                    // A mismatch wins over a coincident timeout.
                    miss       = 1'b1;
                    state_next = S_FAIL;
                end else if (cycle_count == TMO_LAST) begin
                    tmo        = 1'b1;
                    state_next = S_FAIL;
                end
            end
            default: begin
                if (start) begin
                    load       = 1'b1;
                    state_next = S_RUN;
                end
            end
        endcase
    end

    // Expected table: not reset, and frozen while a run is in progress.
    always_ff @(posedge clk) begin
        if (bus.exp_we && (state != S_RUN) && ({1'b0, bus.exp_addr} < DEPTH_L)) begin
            exp_mem[bus.exp_addr] <= bus.exp_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            num_lat     <= '0;
            index       <= '0;
            cycle_count <= '0;
            match_count <= '0;
            timeout     <= 1'b0;
            err_index   <= '0;
            err_got     <= '0;
            err_exp     <= '0;
            err_pc      <= '0;
        end else if (load) begin
            num_lat     <= num_clamped;
            index       <= '0;
            cycle_count <= '0;
            match_count <= '0;
            timeout     <= 1'b0;
            err_index   <= '0;
            err_got     <= '0;
            err_exp     <= '0;
            err_pc      <= '0;
        end else if (state == S_RUN) begin
            // The count freezes on the deciding cycle, so a timeout leaves
            // it at TIMEOUT-1.
            if (state_next == S_RUN) begin
                cycle_count <= cycle_count + 1'b1;
            end
            if (hit) begin
                index       <= index + 1'b1;
                match_count <= match_count + 1'b1;
            end
            if (miss) begin
                err_index <= index;
                err_got   <= bus.wb_data;
                err_exp   <= exp_cur;
                err_pc    <= bus.pc;
            end
            if (tmo) begin
                timeout <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_wb_trace_checker.sv
// tb/tb_wb_trace_checker.sv - directed table-driven bench for wb_trace_checker
module tb_wb_trace_checker;
    localparam int DATA_W  = 32;
    localparam int DEPTH   = 16;
    localparam int ADDR_W  = 4;
    localparam int CNT_W   = 16;
    localparam int TIMEOUT = 20;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [ADDR_W:0]   num_exp;
    logic              done, pass, fail, timeout;
    logic [ADDR_W-1:0] err_index;
    logic [DATA_W-1:0] err_got, err_exp, err_pc;
    logic [CNT_W-1:0]  cycle_count, match_count;

    always #5 clk = ~clk;

    wb_trace_checker_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    wb_trace_checker #(
        .DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W),
        .CNT_W(CNT_W), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .num_exp(num_exp),
        .bus(bus),
        .done(done), .pass(pass), .fail(fail), .timeout(timeout),
        .err_index(err_index), .err_got(err_got), .err_exp(err_exp), .err_pc(err_pc),
        .cycle_count(cycle_count), .match_count(match_count)
    );

    typedef struct {
        logic              start;
        logic [ADDR_W:0]   num;
        logic              wv;
        logic [DATA_W-1:0] wd;
        logic [DATA_W-1:0] pc;
        logic              e_done;
        logic              e_pass;
        logic              e_fail;
        logic [CNT_W-1:0]  e_match;
    } vec_t;

    vec_t              vecs[$];
    logic [DATA_W-1:0] tv [DEPTH];
    int                n_pass  = 0;
    int                n_total = 0;

    function automatic vec_t mk(input logic s, input logic [ADDR_W:0] n, input logic v,
                                input logic [DATA_W-1:0] d, input logic [DATA_W-1:0] p,
                                input logic ed, input logic ep, input logic ef,
                                input logic [CNT_W-1:0] em);
        vec_t r;
        r.start = s; r.num = n; r.wv = v; r.wd = d; r.pc = p;
        r.e_done = ed; r.e_pass = ep; r.e_fail = ef; r.e_match = em;
        return r;
    endfunction

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        start        = 1'b0;
        bus.wb_valid = 1'b0;
        bus.exp_we   = 1'b0;
    endtask

    task automatic wb(input logic [DATA_W-1:0] d, input logic [DATA_W-1:0] p);
        bus.wb_valid = 1'b1;
        bus.wb_data  = d;
        bus.pc       = p;
    endtask

    task automatic do_start(input logic [ADDR_W:0] n);
        idle_in();
        start   = 1'b1;
        num_exp = n;
        tick();
        start   = 1'b0;
    endtask

    task automatic write_tab(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        idle_in();
        bus.exp_we   = 1'b1;
        bus.exp_addr = a;
        bus.exp_data = d;
        tick();
        bus.exp_we   = 1'b0;
    endtask

    task automatic check_err_zero(input string tag);
        check({tag, " err_index"}, 64'(err_index), 64'd0);
        check({tag, " err_got"},   64'(err_got),   64'd0);
        check({tag, " err_exp"},   64'(err_exp),   64'd0);
        check({tag, " err_pc"},    64'(err_pc),    64'd0);
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        num_exp = '0;
        bus.wb_valid = 1'b0; bus.wb_data = '0; bus.pc = '0;
        bus.exp_we = 1'b0; bus.exp_addr = '0; bus.exp_data = '0;
        tick();
        tick();
        check("reset done",  64'(done), 64'd0);
        check("reset pass",  64'(pass), 64'd0);
        check("reset fail",  64'(fail), 64'd0);
        check("reset match", 64'(match_count), 64'd0);
        check("reset cycle", 64'(cycle_count), 64'd0);
        rst = 1'b0;
        tick();

        tv[0] = 32'h5; tv[1] = 32'h7; tv[2] = 32'hA; tv[3] = 32'hFFFF_FFFF;
        for (int i = 4; i < DEPTH; i++) tv[i] = 32'h100 + 32'(i);
        for (int i = 0; i < DEPTH; i++) write_tab(ADDR_W'(i), tv[i]);

        // Scenario 1: four matches with gaps; scenario 2: mismatch on the third.
        vecs.push_back(mk(1, 4, 0, 0,            0,     0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 32'h5,        32'h0, 0, 0, 0, 1));
        vecs.push_back(mk(0, 0, 0, 0,            0,     0, 0, 0, 1));
        vecs.push_back(mk(0, 0, 1, 32'h7,        32'h4, 0, 0, 0, 2));
        vecs.push_back(mk(0, 0, 0, 0,            0,     0, 0, 0, 2));
        vecs.push_back(mk(0, 0, 0, 0,            0,     0, 0, 0, 2));
        vecs.push_back(mk(0, 0, 1, 32'hA,        32'h8, 0, 0, 0, 3));
        vecs.push_back(mk(0, 0, 0, 0,            0,     0, 0, 0, 3));
        vecs.push_back(mk(0, 0, 1, 32'hFFFFFFFF, 32'hC, 1, 1, 0, 4));
        vecs.push_back(mk(0, 0, 0, 0,            0,     1, 1, 0, 4));
        vecs.push_back(mk(1, 4, 0, 0,            0,     0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 32'h5,        32'h0, 0, 0, 0, 1));
        vecs.push_back(mk(0, 0, 1, 32'h7,        32'h4, 0, 0, 0, 2));
        vecs.push_back(mk(0, 0, 1, 32'hB,        32'h8, 1, 0, 1, 2));
        vecs.push_back(mk(0, 0, 1, 32'hA,        32'hC, 1, 0, 1, 2));
        vecs.push_back(mk(0, 0, 1, 32'hFFFFFFFF, 32'h10, 1, 0, 1, 2));

        foreach (vecs[i]) begin
            start        = vecs[i].start;
            num_exp      = vecs[i].num;
            bus.wb_valid = vecs[i].wv;
            bus.wb_data  = vecs[i].wd;
            bus.pc       = vecs[i].pc;
            tick();
            check($sformatf("vec%0d done", i),  64'(done),        64'(vecs[i].e_done));
            check($sformatf("vec%0d pass", i),  64'(pass),        64'(vecs[i].e_pass));
            check($sformatf("vec%0d fail", i),  64'(fail),        64'(vecs[i].e_fail));
            check($sformatf("vec%0d match", i), 64'(match_count), 64'(vecs[i].e_match));
        end
        idle_in();
        check("s2 timeout",   64'(timeout),   64'd0);
        check("s2 err_index", 64'(err_index), 64'd2);
        check("s2 err_got",   64'(err_got),   64'hB);
        check("s2 err_exp",   64'(err_exp),   64'hA);
        check("s2 err_pc",    64'(err_pc),    64'h8);

        // Scenario 3: timeout after TIMEOUT RUN cycles with one of two matched.
        do_start(2);
        wb(32'h5, 32'h0);
        tick();
        idle_in();
        for (int i = 0; i < TIMEOUT - 2; i++) tick();
        check("s3 fail early", 64'(fail), 64'd0);
        tick();
        check("s3 fail",    64'(fail),        64'd1);
        check("s3 timeout", 64'(timeout),     64'd1);
        check("s3 cycle",   64'(cycle_count), 64'(TIMEOUT - 1));
        check("s3 match",   64'(match_count), 64'd1);
        check_err_zero("s3");

        // Scenario 4: empty run passes one RUN cycle later; oversize num_exp clamps.
        do_start(0);
        check("s4 pass early", 64'(pass), 64'd0);
        tick();
        check("s4 pass", 64'(pass), 64'd1);
        do_start(20);
        for (int i = 0; i < DEPTH; i++) begin
            wb(tv[i], 32'(4 * i));
            tick();
            if (i == DEPTH - 2) check("s4 clamp early", 64'(pass), 64'd0);
        end
        idle_in();
        check("s4 clamp pass",  64'(pass),        64'd1);
        check("s4 clamp match", 64'(match_count), 64'(DEPTH));

        // Scenario 5: table write during RUN is ignored, write after PASS is used.
        do_start(2);
        wb(32'h5, 32'h0);
        bus.exp_we = 1'b1; bus.exp_addr = 4'd1; bus.exp_data = 32'h55;
        tick();
        bus.exp_we = 1'b0;
        wb(32'h7, 32'h4);
        tick();
        idle_in();
        check("s5 ignored write pass", 64'(pass), 64'd1);
        write_tab(4'd1, 32'h55);
        do_start(2);
        check("s5 restart match", 64'(match_count), 64'd0);
        check("s5 restart cycle", 64'(cycle_count), 64'd0);
        check("s5 restart done",  64'(done),        64'd0);
        wb(32'h5, 32'h0);
        tick();
        wb(32'h7, 32'h20);
        tick();
        idle_in();
        check("s5 fail",      64'(fail),      64'd1);
        check("s5 err_index", 64'(err_index), 64'd1);
        check("s5 err_got",   64'(err_got),   64'h7);
        check("s5 err_exp",   64'(err_exp),   64'h55);
        check("s5 err_pc",    64'(err_pc),    64'h20);
        do_start(2);
        check_err_zero("s5 restart");
        check("s5 restart fail", 64'(fail), 64'd0);
        wb(32'h5, 32'h0);
        tick();
        wb(32'h55, 32'h4);
        tick();
        idle_in();
        check("s5 new value pass", 64'(pass), 64'd1);
        write_tab(4'd1, 32'h7);

        // Scenario 6: asynchronous reset mid-run, then scenario 1 again.
        do_start(4);
        wb(32'h5, 32'h0);
        tick();
        wb(32'h7, 32'h4);
        tick();
        idle_in();
        check("s6 match before rst", 64'(match_count), 64'd2);
        #2 rst = 1'b1;
        #1;
        check("s6 rst done",    64'(done),        64'd0);
        check("s6 rst pass",    64'(pass),        64'd0);
        check("s6 rst fail",    64'(fail),        64'd0);
        check("s6 rst match",   64'(match_count), 64'd0);
        check("s6 rst cycle",   64'(cycle_count), 64'd0);
        check("s6 rst timeout", 64'(timeout),     64'd0);
        check_err_zero("s6 rst");
        tick();
        rst = 1'b0;
        tick();
        check("s6 idle after rst", 64'(done), 64'd0);
        do_start(4);
        for (int i = 0; i < 4; i++) begin
            wb(tv[i], 32'(4 * i));
            tick();
        end
        idle_in();
        check("s6 rerun pass",  64'(pass),        64'd1);
        check("s6 rerun fail",  64'(fail),        64'd0);
        check("s6 rerun match", 64'(match_count), 64'd4);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
